mips_ex_unit: RTL and testbench
===============================

MIPS_EX_UNIT -- requirements
Module: mips_ex_unit

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; only 32 is required.
REQ-002 Parameter: NREG, 32, register count; register 0 is hardwired to zero.
REQ-003 Reset rst is asynchronous and active-high; clock clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 instr  in  32  instruction in EX: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0].
REQ-007 stall  in  1  when 1, squashes all write/enable outputs.
REQ-008 wb_we, wb_addr, wb_data  in  1/5/32  register-file write port.
REQ-009 rs_data, rt_data  out  32/32  register-file read data for instr rs and instr rt.
REQ-010 alu_hi, alu_lo, zero  out  32/32/1  ALU results; zero = (alu_lo == 0).
REQ-011 Control outputs (all out):
- alu_op (4)
- shamt_ex (5)
- enhilo (1)
- regsel (2): 00 ALU, 01 HI, 10 LO
- regwrite (1)
- rdrt (1): 0 = rd, 1 = rt
- memwrite (1)
- alu_src (2): 00 rt_data, 01 sign-extended imm, 10 zero-extended imm
- gpio_out_en (1)
- gpio_in_en (1)

Function
REQ-012 Register file: 32x32 with two combinational read ports.
- Write occurs on rising clk when wb_we=1 and wb_addr!=0.
- Register 0 always reads 0.
REQ-013 Read bypass: when wb_we=1 and wb_addr==read address!=0, the read port returns wb_data in the same cycle.
REQ-014 ALU operand a = rs_data; operand b is selected by alu_src; value 11 selects 0.
REQ-015 ALU operations by alu_op. alu_hi = 0 except for MULT/MULTU.
- 0 AND, 1 OR, 2 XOR, 3 NOR
- 4 ADD, 5 SUB (modulo 2^32, no overflow trap)
- 6 SLT (signed), 7 SLTU: lo = 1 or 0
- 8 SLL b<<shamt, 9 SRL, 10 SRA b>>>shamt
- 11 MULT signed, 12 MULTU: {hi,lo} = 64-bit product
- 13 LUI lo = b<<16
- 14 and 15: hi = lo = 0
REQ-016 Decode is purely combinational from opcode/funct/shamt; clk is used by the register file only.
REQ-017 R-type (opcode 0) decode: regwrite=1, rdrt=0, alu_src=00, regsel=00, except where noted.
- funct 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU
- funct 00 SLL, 02 SRL, 03 SRA: shamt_ex = instr shamt
- funct 18 MULT, 19 MULTU: regwrite=0, enhilo=1
- funct 10 MFHI: regsel=01; funct 12 MFLO: regsel=10
REQ-018 I-type decode: regwrite=1, rdrt=1.
- 08/09 ADD, alu_src 01
- 0A SLT, alu_src 01; 0B SLTU, alu_src 01
- 0C AND, 0D OR, 0E XOR: alu_src 10
- 0F LUI, alu_src 10
REQ-019 GPIO decode, opcode 0x10:
- funct 00: gpio_in_en=1, regwrite=1, rdrt=1.
- funct 01: gpio_out_en=1, regwrite=0.
REQ-020 Undefined opcode/funct decodes as a NOP: all enables 0, alu_op=0, regsel=00, alu_src=00.
REQ-021 stall=1 forces regwrite, enhilo, memwrite, gpio_out_en and gpio_in_en to 0; other outputs are unchanged.
REQ-022 memwrite is always 0; no store instructions are decoded.
REQ-023 shamt_ex=0 for all non-shift instructions.

Reset
REQ-024 rst=1 asynchronously clears all 32 registers to 0; rs_data and rt_data read 0 while reset is held.
REQ-025 Combinational outputs follow the inputs during reset; a write during reset is ignored.

Verification
REQ-026 Reset, write r5=0x12345678, read rs=5 -> rs_data=0x12345678; write r0=0xFFFFFFFF -> r0 reads 0.
REQ-027 r1=7, r2=9, instr ADD rd=3 -> alu_lo=16, regwrite=1, rdrt=0; SUB -> 0xFFFFFFFE, zero=0.
REQ-028 MULT r1=0xFFFFFFFF, r2=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, enhilo=1, regwrite=0; MULTU -> hi=1, lo=0xFFFFFFFE.
REQ-029 ADDI imm=0xFFFF, rs=5 -> lo=4, alu_src=01; ORI imm=0xFFFF, rs=0 -> lo=0x0000FFFF; LUI 0x1234 -> lo=0x12340000.
REQ-030 SRA shamt=4 on rt=0x80000000 -> lo=0xF8000000; SRL -> 0x08000000; SLT -1 vs 1 -> 1; SLTU -> 0.
REQ-031 GPIO-in instr with stall=1 -> gpio_in_en=0, regwrite=0; stall=0 -> both 1; same-cycle write/read bypass returns the new data.

Source files
------------

// File: rtl/mips_ex_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_ex_unit                                                 |
// | Description : MIPS-style execute stage with a bypassed 32x32 register file,|
// |               combinational decode and an ALU with a HI/LO multiplier.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mips_ex_unit #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              stall,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] alu_hi,
    output logic [DATA_W-1:0] alu_lo,
    output logic              zero,
    output logic [3:0]        alu_op,
    output logic [4:0]        shamt_ex,
    output logic              enhilo,
    output logic [1:0]        regsel,
    output logic              regwrite,
    output logic              rdrt,
    output logic              memwrite,
    output logic [1:0]        alu_src,
    output logic              gpio_out_en,
    output logic              gpio_in_en
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_GPIO  = 6'h10;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_SRA   = 6'h03;
    localparam logic [5:0] c_FN_MFHI  = 6'h10;
    localparam logic [5:0] c_FN_MFLO  = 6'h12;
    localparam logic [5:0] c_FN_MULT  = 6'h18;
    localparam logic [5:0] c_FN_MULTU = 6'h19;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_SLTU  = 6'h2B;
    localparam logic [5:0] c_FN_GIN   = 6'h00;
    localparam logic [5:0] c_FN_GOUT  = 6'h01;

    localparam logic [3:0] c_ALU_AND   = 4'd0;
    localparam logic [3:0] c_ALU_OR    = 4'd1;
    localparam logic [3:0] c_ALU_XOR   = 4'd2;
    localparam logic [3:0] c_ALU_NOR   = 4'd3;
    localparam logic [3:0] c_ALU_ADD   = 4'd4;
    localparam logic [3:0] c_ALU_SUB   = 4'd5;
    localparam logic [3:0] c_ALU_SLT   = 4'd6;
    localparam logic [3:0] c_ALU_SLTU  = 4'd7;
    localparam logic [3:0] c_ALU_SLL   = 4'd8;
    localparam logic [3:0] c_ALU_SRL   = 4'd9;
    localparam logic [3:0] c_ALU_SRA   = 4'd10;
    localparam logic [3:0] c_ALU_MULT  = 4'd11;
    localparam logic [3:0] c_ALU_MULTU = 4'd12;
    localparam logic [3:0] c_ALU_LUI   = 4'd13;

    localparam logic [1:0] c_SRC_RT  = 2'b00;
    localparam logic [1:0] c_SRC_SXI = 2'b01;
    localparam logic [1:0] c_SRC_ZXI = 2'b10;

    localparam logic [1:0] c_SEL_HI = 2'b01;
    localparam logic [1:0] c_SEL_LO = 2'b10;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;

    assign w_opcode = instr[31:26];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_shamt  = instr[10:6];
    assign w_funct  = instr[5:0];
    assign w_imm    = instr[15:0];

    // ---------------- register file ----------------
    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != 5'd0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Reads return zero while reset is held, then bypass an in-flight write.
    always_comb begin
        rs_data = '0;
        if (!rst && (w_rs != 5'd0)) begin
            if (wb_we && (wb_addr == w_rs)) begin
                rs_data = wb_data;
            end else begin
                rs_data = r_regs[w_rs];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (!rst && (w_rt != 5'd0)) begin
            if (wb_we && (wb_addr == w_rt)) begin
                rt_data = wb_data;
            end else begin
                rt_data = r_regs[w_rt];
            end
        end
    end

    // ---------------- decode ----------------
    logic       w_enhilo;
    logic       w_regwrite;
    logic       w_gpio_out_en;
    logic       w_gpio_in_en;

    always_comb begin
        alu_op        = c_ALU_AND;
        shamt_ex      = 5'd0;
        w_enhilo      = 1'b0;
        regsel        = 2'b00;
        w_regwrite    = 1'b0;
        rdrt          = 1'b0;
        alu_src       = c_SRC_RT;
        w_gpio_out_en = 1'b0;
        w_gpio_in_en  = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_regwrite = 1'b1;
                case (w_funct)
                    c_FN_ADD, c_FN_ADDU: alu_op = c_ALU_ADD;
                    c_FN_SUB, c_FN_SUBU: alu_op = c_ALU_SUB;
                    c_FN_AND:            alu_op = c_ALU_AND;
                    c_FN_OR:             alu_op = c_ALU_OR;
                    c_FN_XOR:            alu_op = c_ALU_XOR;
                    c_FN_NOR:            alu_op = c_ALU_NOR;
                    c_FN_SLT:            alu_op = c_ALU_SLT;
                    c_FN_SLTU:           alu_op = c_ALU_SLTU;
                    c_FN_SLL: begin
                        alu_op   = c_ALU_SLL;
                        shamt_ex = w_shamt;
                    end
                    c_FN_SRL: begin
                        alu_op   = c_ALU_SRL;
                        shamt_ex = w_shamt;
                    end
                    c_FN_SRA: begin
                        alu_op   = c_ALU_SRA;
                        shamt_ex = w_shamt;
                    end
                    c_FN_MULT: begin
                        alu_op     = c_ALU_MULT;
                        w_regwrite = 1'b0;
                        w_enhilo   = 1'b1;
                    end
                    c_FN_MULTU: begin
                        alu_op     = c_ALU_MULTU;
                        w_regwrite = 1'b0;
                        w_enhilo   = 1'b1;
                    end
                    c_FN_MFHI: regsel = c_SEL_HI;
                    c_FN_MFLO: regsel = c_SEL_LO;
                    default:   w_regwrite = 1'b0;
                endcase
            end
            c_OP_ADDI, c_OP_ADDIU: begin
                alu_op     = c_ALU_ADD;
                alu_src    = c_SRC_SXI;
                w_regwrite = 1'b1;
                rdrt       = 1'b1;
            end
            c_OP_SLTI: begin
                alu_op     = c_ALU_SLT;
                alu_src    = c_SRC_SXI;
                w_regwrite = 1'b1;
                rdrt       = 1'b1;
            end
            c_OP_SLTIU: begin
                alu_op     = c_ALU_SLTU;
                alu_src    = c_SRC_SXI;
                w_regwrite = 1'b1;
                rdrt       = 1'b1;
            end
            c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
                alu_op     = (w_opcode == c_OP_ANDI) ? c_ALU_AND :
                             (w_opcode == c_OP_ORI)  ? c_ALU_OR  : c_ALU_XOR;
                alu_src    = c_SRC_ZXI;
                w_regwrite = 1'b1;
                rdrt       = 1'b1;
            end
            c_OP_LUI: begin
                alu_op     = c_ALU_LUI;
                alu_src    = c_SRC_ZXI;
                w_regwrite = 1'b1;
                rdrt       = 1'b1;
            end
            c_OP_GPIO: begin
                if (w_funct == c_FN_GIN) begin
                    w_gpio_in_en = 1'b1;
                    w_regwrite   = 1'b1;
                    rdrt         = 1'b1;
                end else if (w_funct == c_FN_GOUT) begin
                    w_gpio_out_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Stall only kills side effects; datapath selects stay visible.
    assign regwrite    = w_regwrite    & ~stall;
    assign enhilo      = w_enhilo      & ~stall;
    assign gpio_out_en = w_gpio_out_en & ~stall;
    assign gpio_in_en  = w_gpio_in_en  & ~stall;
    assign memwrite    = 1'b0;

    // ---------------- ALU ----------------
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0] w_prod_u;

    assign w_a = rs_data;

    always_comb begin
        case (alu_src)
            c_SRC_RT:  w_b = rt_data;
            c_SRC_SXI: w_b = {{(DATA_W-16){w_imm[15]}}, w_imm};
            c_SRC_ZXI: w_b = {{(DATA_W-16){1'b0}}, w_imm};
            default:   w_b = '0;
        endcase
    end

    assign w_prod_s = {{DATA_W{w_a[DATA_W-1]}}, w_a} * {{DATA_W{w_b[DATA_W-1]}}, w_b};
    assign w_prod_u = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};

    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (alu_op)
            c_ALU_AND:   alu_lo = w_a & w_b;
            c_ALU_OR:    alu_lo = w_a | w_b;
            c_ALU_XOR:   alu_lo = w_a ^ w_b;
            c_ALU_NOR:   alu_lo = ~(w_a | w_b);
            c_ALU_ADD:   alu_lo = w_a + w_b;
            c_ALU_SUB:   alu_lo = w_a - w_b;
            c_ALU_SLT:   alu_lo = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            c_ALU_SLTU:  alu_lo = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
            c_ALU_SLL:   alu_lo = w_b << shamt_ex;
            c_ALU_SRL:   alu_lo = w_b >> shamt_ex;
            c_ALU_SRA:   alu_lo = $signed(w_b) >>> shamt_ex;
            c_ALU_MULT:  {alu_hi, alu_lo} = w_prod_s;
            c_ALU_MULTU: {alu_hi, alu_lo} = w_prod_u;
            c_ALU_LUI:   alu_lo = w_b << 16;
            default: ;
        endcase
    end

    assign zero = (alu_lo == '0);

endmodule
`default_nettype wire

// File: tb/tb_mips_ex_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mips_ex_unit                                              |
// | Description : Directed vector table plus randomized instruction stream     |
// |               compared against an instruction-level reference model.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mips_ex_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs_data, rt_data, alu_hi, alu_lo;
    logic        zero;
    logic [3:0]  alu_op;
    logic [4:0]  shamt_ex;
    logic        enhilo, regwrite, rdrt, memwrite, gpio_out_en, gpio_in_en;
    logic [1:0]  regsel, alu_src;
    logic [18:0] dut_ctl;

    mips_ex_unit #(.DATA_W(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .stall(stall),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs_data(rs_data), .rt_data(rt_data), .alu_hi(alu_hi), .alu_lo(alu_lo),
        .zero(zero), .alu_op(alu_op), .shamt_ex(shamt_ex), .enhilo(enhilo),
        .regsel(regsel), .regwrite(regwrite), .rdrt(rdrt), .memwrite(memwrite),
        .alu_src(alu_src), .gpio_out_en(gpio_out_en), .gpio_in_en(gpio_in_en)
    );

    always #5 clk = ~clk;

    assign dut_ctl = {alu_op, shamt_ex, enhilo, regsel, regwrite, rdrt,
                      memwrite, alu_src, gpio_out_en, gpio_in_en};

    int checks = 0;
    int errors = 0;
    logic [31:0] m_regs [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic write_reg(input int addr, input logic [31:0] data);
        @(negedge clk);
        wb_we   = 1'b1;
        wb_addr = 5'(addr);
        wb_data = data;
        @(posedge clk);
        #1;
        wb_we = 1'b0;
        if (addr != 0 && !rst) m_regs[addr] = data;
    endtask

    // Reference: each instruction's meaning written out directly.
    task automatic m_eval(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] rtv,
                          input logic stl, output logic [31:0] hi, output logic [31:0] lo,
                          output logic [18:0] ctl);
        logic [3:0]  op;
        logic [4:0]  sh;
        logic [1:0]  rsel, src;
        logic        eh, rw, rd_rt, gout, gin;
        logic [31:0] sx, zx;
        logic [63:0] p;
        op = 0; sh = 0; rsel = 0; src = 0; eh = 0; rw = 0; rd_rt = 0; gout = 0; gin = 0;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        hi = 0;
        lo = a & rtv;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20, 6'h21: begin op = 4; rw = 1; lo = a + rtv; end
                6'h22, 6'h23: begin op = 5; rw = 1; lo = a - rtv; end
                6'h24: begin op = 0; rw = 1; lo = a & rtv; end
                6'h25: begin op = 1; rw = 1; lo = a | rtv; end
                6'h26: begin op = 2; rw = 1; lo = a ^ rtv; end
                6'h27: begin op = 3; rw = 1; lo = ~(a | rtv); end
                6'h2A: begin op = 6; rw = 1; lo = ($signed(a) < $signed(rtv)) ? 1 : 0; end
                6'h2B: begin op = 7; rw = 1; lo = (a < rtv) ? 1 : 0; end
                6'h00: begin op = 8;  rw = 1; sh = ins[10:6]; lo = rtv << sh; end
                6'h02: begin op = 9;  rw = 1; sh = ins[10:6]; lo = rtv >> sh; end
                6'h03: begin op = 10; rw = 1; sh = ins[10:6]; lo = 32'($signed(rtv) >>> sh); end
                6'h18: begin
                    op = 11; eh = 1;
                    p = 64'(longint'($signed(a)) * longint'($signed(rtv)));
                    hi = p[63:32]; lo = p[31:0];
                end
                6'h19: begin
                    op = 12; eh = 1;
                    p = {32'h0, a} * {32'h0, rtv};
                    hi = p[63:32]; lo = p[31:0];
                end
                6'h10: begin rw = 1; rsel = 2'b01; end
                6'h12: begin rw = 1; rsel = 2'b10; end
                default: ;
            endcase
            6'h08, 6'h09: begin op = 4; src = 1; rw = 1; rd_rt = 1; lo = a + sx; end
            6'h0A: begin op = 6; src = 1; rw = 1; rd_rt = 1; lo = ($signed(a) < $signed(sx)) ? 1 : 0; end
            6'h0B: begin op = 7; src = 1; rw = 1; rd_rt = 1; lo = (a < sx) ? 1 : 0; end
            6'h0C: begin op = 0; src = 2; rw = 1; rd_rt = 1; lo = a & zx; end
            6'h0D: begin op = 1; src = 2; rw = 1; rd_rt = 1; lo = a | zx; end
            6'h0E: begin op = 2; src = 2; rw = 1; rd_rt = 1; lo = a ^ zx; end
            6'h0F: begin op = 13; src = 2; rw = 1; rd_rt = 1; lo = {ins[15:0], 16'h0}; end
            6'h10: begin
                if (ins[5:0] == 6'h00) begin gin = 1; rw = 1; rd_rt = 1; end
                else if (ins[5:0] == 6'h01) gout = 1;
            end
            default: ;
        endcase
        if (stl) begin rw = 0; eh = 0; gout = 0; gin = 0; end
        ctl = {op, sh, eh, rsel, rw, rd_rt, 1'b0, src, gout, gin};
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        stl;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        z;
        logic        rw;
        logic        rd_rt;
        logic        eh;
        logic        gin;
        logic [1:0]  src;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] e_hi, e_lo, a_v, b_v;
        logic [18:0] e_ctl;
        int          k;

        vecs[0]  = '{"add",      r_ins(1,2,3,0,'h20), 0, 0, 32'd16,        0, 1, 0, 0, 0, 2'd0};
        vecs[1]  = '{"sub",      r_ins(1,2,3,0,'h22), 0, 0, 32'hFFFFFFFE,  0, 1, 0, 0, 0, 2'd0};
        vecs[2]  = '{"sub_zero", r_ins(1,1,3,0,'h23), 0, 0, 32'h0,         1, 1, 0, 0, 0, 2'd0};
        vecs[3]  = '{"mult",     r_ins(3,4,0,0,'h18), 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 1, 0, 2'd0};
        vecs[4]  = '{"multu",    r_ins(3,4,0,0,'h19), 0, 32'h1,        32'hFFFFFFFE, 0, 0, 0, 1, 0, 2'd0};
        vecs[5]  = '{"addi",     i_ins('h08,5,8,'hFFFF), 0, 0, 32'd4,      0, 1, 1, 0, 0, 2'd1};
        vecs[6]  = '{"ori",      i_ins('h0D,0,8,'hFFFF), 0, 0, 32'hFFFF,   0, 1, 1, 0, 0, 2'd2};
        vecs[7]  = '{"lui",      i_ins('h0F,0,8,'h1234), 0, 0, 32'h12340000, 0, 1, 1, 0, 0, 2'd2};
        vecs[8]  = '{"sra",      r_ins(0,6,3,4,'h03), 0, 0, 32'hF8000000,  0, 1, 0, 0, 0, 2'd0};
        vecs[9]  = '{"srl",      r_ins(0,6,3,4,'h02), 0, 0, 32'h08000000,  0, 1, 0, 0, 0, 2'd0};
        vecs[10] = '{"slt",      r_ins(3,7,3,0,'h2A), 0, 0, 32'h1,         0, 1, 0, 0, 0, 2'd0};
        vecs[11] = '{"sltu",     r_ins(3,7,3,0,'h2B), 0, 0, 32'h0,         1, 1, 0, 0, 0, 2'd0};
        vecs[12] = '{"gin_stall", {6'h10, 26'h0},     1, 0, 32'h0,         1, 0, 1, 0, 0, 2'd0};
        vecs[13] = '{"gin",       {6'h10, 26'h0},     0, 0, 32'h0,         1, 1, 1, 0, 1, 2'd0};
        vecs[14] = '{"undef",    i_ins('h3F,1,2,0),   0, 0, 32'h1,         0, 0, 0, 0, 0, 2'd0};
        vecs[15] = '{"mult_stall", r_ins(3,4,0,0,'h18), 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 2'd0};
        vecs[16] = '{"slti",     i_ins('h0A,3,8,1),   0, 0, 32'h1,         0, 1, 1, 0, 0, 2'd1};

        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        rst = 1; instr = r_ins(5,6,3,0,'h20); stall = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;

        // Reset state: reads are zero, decode follows the instruction.
        #2;
        chk("rst_rs", rs_data, 0);
        chk("rst_rt", rt_data, 0);
        chk("rst_regwrite", regwrite, 1);
        @(negedge clk); @(negedge clk);
        rst = 0;

        write_reg(5, 32'h12345678);
        instr = r_ins(5,0,0,0,'h20);
        #1 chk("r5_read", rs_data, 32'h12345678);
        write_reg(0, 32'hFFFFFFFF);
        instr = r_ins(0,0,0,0,'h20);
        #1 chk("r0_read", rs_data, 0);

        // Same-cycle bypass, then the stored value after the edge.
        @(negedge clk);
        wb_we = 1; wb_addr = 9; wb_data = 32'hA5A5_5A5A;
        instr = r_ins(0,9,0,0,'h20);
        #1 chk("bypass_rt", rt_data, 32'hA5A5_5A5A);
        @(posedge clk); #1;
        wb_we = 0; m_regs[9] = 32'hA5A5_5A5A;
        chk("bypass_stored", rt_data, 32'hA5A5_5A5A);
        @(negedge clk);
        wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
        instr = r_ins(0,0,0,0,'h20);
        #1 chk("bypass_r0", rs_data, 0);
        @(posedge clk); #1 wb_we = 0;

        write_reg(1, 7);
        write_reg(2, 9);
        write_reg(3, 32'hFFFFFFFF);
        write_reg(4, 2);
        write_reg(5, 5);
        write_reg(6, 32'h80000000);
        write_reg(7, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            instr = vecs[i].ins;
            stall = vecs[i].stl;
            #1;
            chk({vecs[i].name, ".hi"},       alu_hi,   vecs[i].hi);
            chk({vecs[i].name, ".lo"},       alu_lo,   vecs[i].lo);
            chk({vecs[i].name, ".zero"},     zero,     vecs[i].z);
            chk({vecs[i].name, ".regwrite"}, regwrite, vecs[i].rw);
            chk({vecs[i].name, ".rdrt"},     rdrt,     vecs[i].rd_rt);
            chk({vecs[i].name, ".enhilo"},   enhilo,   vecs[i].eh);
            chk({vecs[i].name, ".gpio_in"},  gpio_in_en, vecs[i].gin);
            chk({vecs[i].name, ".alu_src"},  alu_src,  vecs[i].src);
            chk({vecs[i].name, ".memwrite"}, memwrite, 0);
        end
        stall = 0;

        // Asynchronous reset mid-cycle clears the file; a write during reset is lost.
        @(negedge clk);
        instr = r_ins(5,1,0,0,'h20);
        #2 rst = 1;
        #1 chk("async_rst_rs", rs_data, 0);
        wb_we = 1; wb_addr = 10; wb_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        wb_we = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        #1 chk("rst_cleared_r5", rs_data, 0);
        instr = r_ins(10,1,0,0,'h20);
        #1 chk("rst_write_ignored", rs_data, 0);
        chk("rst_cleared_r1", rt_data, 0);

        // Randomized instruction stream against the reference model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            k = $urandom_range(0, 4);
            instr = $urandom;
            case (k)
                0: begin
                    instr[31:26] = 6'h00;
                    case ($urandom_range(0, 14))
                        0: instr[5:0] = 6'h20;  1: instr[5:0] = 6'h22;  2: instr[5:0] = 6'h24;
                        3: instr[5:0] = 6'h25;  4: instr[5:0] = 6'h26;  5: instr[5:0] = 6'h27;
                        6: instr[5:0] = 6'h2A;  7: instr[5:0] = 6'h2B;  8: instr[5:0] = 6'h00;
                        9: instr[5:0] = 6'h02; 10: instr[5:0] = 6'h03; 11: instr[5:0] = 6'h18;
                        12: instr[5:0] = 6'h19; 13: instr[5:0] = 6'h10; default: instr[5:0] = 6'h12;
                    endcase
                end
                1: instr[31:26] = 6'(8 + $urandom_range(0, 7));
                2: begin instr[31:26] = 6'h10; instr[5:0] = 6'($urandom_range(0, 2)); end
                3: instr[31:26] = 6'h00;
                default: ;
            endcase
            stall   = ($urandom_range(0, 3) == 0);
            wb_we   = $urandom_range(0, 1);
            wb_addr = 5'($urandom);
            wb_data = $urandom;
            #1;
            a_v = (instr[25:21] == 0) ? 0 : (wb_we && wb_addr == instr[25:21]) ? wb_data : m_regs[instr[25:21]];
            b_v = (instr[20:16] == 0) ? 0 : (wb_we && wb_addr == instr[20:16]) ? wb_data : m_regs[instr[20:16]];
            m_eval(instr, a_v, b_v, stall, e_hi, e_lo, e_ctl);
            chk($sformatf("rnd%0d.rs_data", n), rs_data, a_v);
            chk($sformatf("rnd%0d.rt_data", n), rt_data, b_v);
            chk($sformatf("rnd%0d.hi i=%h", n, instr), alu_hi, e_hi);
            chk($sformatf("rnd%0d.lo i=%h", n, instr), alu_lo, e_lo);
            chk($sformatf("rnd%0d.zero", n), zero, (e_lo == 0));
            chk($sformatf("rnd%0d.ctl i=%h", n, instr), dut_ctl, e_ctl);
            @(posedge clk); #1;
            if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
        end
        wb_we = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
